// File: rtl/muldiv_sequencer.sv
// Iterative 32-bit multiply/divide sequencer.
// Shift-add multiply and restoring divide, one radix-2 step per clock. Every
// operation takes a fixed 33 edges from acceptance to the DONE pulse.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | waiting for START with a valid SELECT code
// CALC  | 32 radix-2 iterations, one per edge
// FIX   | sign correction, RESULT write, DONE pulse
module muldiv_sequencer (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        START,
    input  logic [4:0]  SELECT,
    input  logic [31:0] DATA1,
    input  logic [31:0] DATA2,
    input  logic        ABORT,
    output logic        BUSY,
    output logic        DONE,
    output logic [31:0] RESULT
);

    typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

    state_t      state_q, state_d;
    logic [5:0]  cnt_q, cnt_d;
    logic [31:0] opa_q, opa_d;        // multiplicand, or divisor magnitude
    logic [31:0] hi_q, hi_d;          // product high half, or partial remainder
    logic [31:0] lo_q, lo_d;          // multiplier / product low half, or dividend / quotient
    logic        is_div_q, is_div_d;
    logic [1:0]  var_q, var_d;        // SELECT[3:2]: variant within mul or div group
    logic        neg_q, neg_d;        // product or quotient must be negated
    logic        neg_rem_q, neg_rem_d;
    logic        div_zero_q, div_zero_d;
    logic [31:0] result_q, result_d;
    logic        done_q, done_d;

    // Operand decode for the request presented in IDLE.
    logic        sel_valid, sel_div, a_signed, b_signed, a_neg, b_neg;
    logic [1:0]  sel_var;
    logic [31:0] mag_a, mag_b;

    assign sel_valid = (SELECT[1:0] == 2'b01);
    assign sel_div   = SELECT[4];
    assign sel_var   = SELECT[3:2];
    assign a_signed  = sel_div ? ~SELECT[2] : SELECT[2];
    assign b_signed  = sel_div ? ~SELECT[2] : (sel_var == 2'b01);
    assign a_neg     = a_signed & DATA1[31];
    assign b_neg     = b_signed & DATA2[31];
    assign mag_a     = a_neg ? (32'd0 - DATA1) : DATA1;
    assign mag_b     = b_neg ? (32'd0 - DATA2) : DATA2;

    // One iteration step of each algorithm.
    logic [32:0] mul_sum;
    logic [32:0] div_shl;
    logic [31:0] div_diff;
    logic        div_ge;

    assign mul_sum  = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opa_q} : 33'd0);
    assign div_shl  = {hi_q, lo_q[31]};
    assign div_ge   = (div_shl >= {1'b0, opa_q});
    // The remainder stays below the divisor, so 32 bits of difference suffice.
    assign div_diff = div_shl[31:0] - opa_q;

    // Final sign correction applied in FIX.
    logic [63:0] prod_fix;
    logic [31:0] quo_fix, rem_fix, final_res;

    assign prod_fix = neg_q ? (64'd0 - {hi_q, lo_q}) : {hi_q, lo_q};
    assign quo_fix  = div_zero_q ? 32'hFFFF_FFFF : (neg_q ? (32'd0 - lo_q) : lo_q);
    assign rem_fix  = neg_rem_q ? (32'd0 - hi_q) : hi_q;
    assign final_res = is_div_q ? (var_q[1] ? rem_fix : quo_fix)
                                : ((var_q == 2'b00) ? prod_fix[31:0] : prod_fix[63:32]);

    // Next-state and datapath update.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        opa_d      = opa_q;
        hi_d       = hi_q;
        lo_d       = lo_q;
        is_div_d   = is_div_q;
        var_d      = var_q;
        neg_d      = neg_q;
        neg_rem_d  = neg_rem_q;
        div_zero_d = div_zero_q;
        result_d   = result_q;
        done_d     = 1'b0;

        case (state_q)
            IDLE: begin
                if (START && sel_valid && !ABORT) begin
                    state_d    = CALC;
                    cnt_d      = 6'd0;
                    opa_d      = sel_div ? mag_b : mag_a;
                    lo_d       = sel_div ? mag_a : mag_b;
                    hi_d       = 32'd0;
                    is_div_d   = sel_div;
                    var_d      = sel_var;
                    neg_d      = a_neg ^ b_neg;
                    neg_rem_d  = a_neg;
                    div_zero_d = (DATA2 == 32'd0);
                end
            end
            CALC: begin
                if (ABORT) begin
                    state_d = IDLE;
                end else begin
                    if (is_div_q) begin
                        hi_d = div_ge ? div_diff : div_shl[31:0];
                        lo_d = {lo_q[30:0], div_ge};
                    end else begin
                        hi_d = mul_sum[32:1];
                        lo_d = {mul_sum[0], lo_q[31:1]};
                    end
                    if (cnt_q < 6'd32) begin
                        cnt_d = cnt_q + 6'd1;
                    end
                    if (cnt_q == 6'd31) begin
                        state_d = FIX;
                    end
                end
            end
            FIX: begin
                state_d = IDLE;
                if (!ABORT) begin
                    result_d = final_res;
                    done_d   = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers, cleared asynchronously.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q    <= IDLE;
            cnt_q      <= 6'd0;
            opa_q      <= 32'd0;
            hi_q       <= 32'd0;
            lo_q       <= 32'd0;
            is_div_q   <= 1'b0;
            var_q      <= 2'b00;
            neg_q      <= 1'b0;
            neg_rem_q  <= 1'b0;
            div_zero_q <= 1'b0;
            result_q   <= 32'd0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            opa_q      <= opa_d;
            hi_q       <= hi_d;
            lo_q       <= lo_d;
            is_div_q   <= is_div_d;
            var_q      <= var_d;
            neg_q      <= neg_d;
            neg_rem_q  <= neg_rem_d;
            div_zero_q <= div_zero_d;
            result_q   <= result_d;
            done_q     <= done_d;
        end
    end

    assign BUSY   = (state_q != IDLE);
    assign DONE   = done_q;
    assign RESULT = result_q;

endmodule

// File: doc/muldiv_sequencer.md
MULDIV_SEQUENCER -- requirements
Module: muldiv_sequencer

Interface
REQ-001 The block SHALL have no parameters; all widths are fixed at 32-bit data and 5-bit SELECT.
REQ-002 CLK  input  1  system clock; all state SHALL update on the rising edge.
REQ-003 RESET  input  1  asynchronous, active-high reset.
REQ-004 START  input  1  request; sampled only on a rising edge while in IDLE.
REQ-005 SELECT  input  5  operation code, sampled with START.
REQ-006 DATA1  input  32  rs1 operand, latched with START.
REQ-007 DATA2  input  32  rs2 operand, latched with START.
REQ-008 ABORT  input  1  pipeline flush; cancels any operation in flight.
REQ-009 BUSY  output  1  operation in flight; the pipeline stalls on it.
REQ-010 DONE  output  1  one-cycle pulse; RESULT is valid.
REQ-011 RESULT  output  32  registered result, held until the next DONE or reset.

Function
REQ-012 Accepted SELECT codes SHALL be:
- MUL 00001
- MULH 00101
- MULHU 01001
- MULHSU 01101
- DIV 10001
- DIVU 10101
- REM 11001
- REMU 11101
REQ-013 START with any other SELECT code SHALL be ignored: state stays IDLE, BUSY stays 0, DONE stays 0.
REQ-014 The FSM SHALL have three states: IDLE, CALC and FIX.
REQ-015 On edge E0, IDLE with START and a valid SELECT SHALL go to CALC: latch operands and SELECT, clear the 6-bit iteration counter, set BUSY=1.
REQ-016 CALC SHALL perform one radix-2 iteration per edge: shift-add for multiplies, restoring shift-subtract for divides.
REQ-017 CALC SHALL run exactly 32 iterations (E1..E32), then go to FIX.
REQ-018 FIX (edge E33) SHALL apply sign correction, write RESULT, pulse DONE=1, clear BUSY and return to IDLE.
REQ-019 DONE SHALL be high only between E33 and E34.
REQ-020 Latency SHALL be fixed at 33 edges for every operation, operand value and special case.
REQ-021 Throughput SHALL be one operation per 34 cycles; a START at E34 SHALL be accepted.
REQ-022 START while BUSY=1 SHALL be ignored, and the latched operands SHALL remain unchanged.
REQ-023 Signed operands SHALL be converted to magnitudes on entry and the sign fixed in FIX:
- MULH: both operands signed.
- MULHSU: DATA1 signed, DATA2 unsigned.
- MULHU, DIVU, REMU: unsigned.
REQ-024 MUL SHALL return product[31:0]; MULH, MULHSU and MULHU SHALL return the full 64-bit product bits [63:32].
REQ-025 DIV and REM SHALL truncate toward zero, and the remainder sign SHALL follow DATA1.
REQ-026 Divide by zero SHALL give DIV/DIVU = 0xFFFFFFFF and REM/REMU = DATA1, with no exception.
REQ-027 Signed overflow (0x80000000 / 0xFFFFFFFF) SHALL give DIV = 0x80000000 and REM = 0.
REQ-028 ABORT=1 on any edge in CALC or FIX SHALL go to IDLE with BUSY=0 and no DONE; RESULT SHALL keep its prior value.
REQ-029 ABORT in IDLE SHALL have no effect.
REQ-030 ABORT together with START in IDLE SHALL have ABORT win: the request is not accepted.
REQ-031 The counter SHALL never wrap; it saturates at 32 and is cleared on acceptance.

Reset
REQ-032 RESET=1 SHALL immediately, without waiting for CLK, force state IDLE, BUSY=0, DONE=0, RESULT=0x00000000 and counter 0.
REQ-033 Reset mid-operation SHALL discard the operation, and no DONE SHALL follow.
REQ-034 The first START SHALL be accepted on the first rising edge after RESET deasserts.

Verification
REQ-035 MUL DATA1=7, DATA2=0xFFFFFFFD -> RESULT=0xFFFFFFEB; BUSY high E0..E33; DONE only between E33 and E34.
REQ-036 High-half multiplies:
- MULH 0x80000000*0x80000000 -> 0x40000000.
- MULHU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFE.
- MULHSU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFF.
REQ-037 Divides:
- DIV 0xFFFFFFF9/2 -> 0xFFFFFFFD; REM -> 0xFFFFFFFF.
- DIVU 100/7 -> 14; REMU -> 2.
REQ-038 Special cases:
- DIV 5/0 -> 0xFFFFFFFF; REM 5/0 -> 5.
- DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM -> 0.
- Each special case takes the full 33-edge latency.
REQ-039 Abort and handshake:
- ABORT at E10 -> BUSY=0 after E10, no DONE; a new MUL 3*4 START then returns 12.
- START at E5 while busy -> ignored.
- SELECT=00000 -> no BUSY.
REQ-040 Reset mid-operation: RESET asserted at E20 plus half a cycle -> BUSY, DONE and RESULT are 0 at once; after release, DIVU 9/3 -> 3.
